// File: rtl/tt6581_pkg.sv
// rtl/tt6581_pkg.sv - shared types and default widths for the multiplier arbiter
package tt6581_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    WAIT   = 2'd3
  } arb_state_e;

  localparam int MULT_A_W = 14;
  localparam int MULT_B_W = 8;
  localparam int MULT_P_W = 14;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner select, first active request above ptr (wrapping)
module arb_pick #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx
);

  // ptr = NUM_REQ-1 makes the search start at index 0, i.e. fixed priority
  always_comb begin
    logic found;
    int   cand;
    found      = 1'b0;
    cand       = 0;
    win_onehot = '0;
    win_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found            = 1'b1;
        win_onehot[cand] = 1'b1;
        win_idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - shares one multiplier among NUM_REQ requesters
// MULT_ARB_RR_EN selects round-robin arbitration; fixed priority otherwise.
module mult_arbiter
  import tt6581_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int A_W     = MULT_A_W,
  parameter int B_W     = MULT_B_W,
  parameter int P_W     = MULT_P_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*A_W-1:0] op_a_i,
  input  logic [NUM_REQ*B_W-1:0] op_b_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [P_W-1:0]         prod_o,
  output logic                   busy_o,
  output logic                   mult_start_o,
  output logic [A_W-1:0]         mult_op_a_o,
  output logic [B_W-1:0]         mult_op_b_o,
  input  logic                   mult_ready_i,
  input  logic [P_W-1:0]         mult_prod_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               grant_fire;
  logic               done_fire;

  assign grant_fire = (state_q == IDLE) && (|req_i) && mult_ready_i;
  assign done_fire  = (state_q == WAIT) && mult_ready_i;

`ifdef MULT_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else if (grant_fire) begin
      ptr_q <= win_idx;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = IDX_W'(NUM_REQ - 1);
`endif

  arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (req_i),
    .ptr        (ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // SETTLE exists only to ignore the ready left high from before the start pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_fire) state_d = ISSUE;
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = WAIT;
      WAIT:    if (mult_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q != IDLE);
    mult_start_o = (state_q == ISSUE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_o       <= '0;
      done_o      <= '0;
      prod_o      <= '0;
      mult_op_a_o <= '0;
      mult_op_b_o <= '0;
      owner_q     <= '0;
    end else begin
      gnt_o  <= grant_fire ? win_onehot : '0;
      done_o <= done_fire ? (NUM_REQ'(1) << owner_q) : '0;
      if (grant_fire) begin
        mult_op_a_o <= op_a_i[int'(win_idx)*A_W +: A_W];
        mult_op_b_o <= op_b_i[int'(win_idx)*B_W +: B_W];
        owner_q     <= win_idx;
      end
      if (done_fire) begin
        prod_o <= mult_prod_i;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter
module tb_mult_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic [2:0]  req_i;
  logic [41:0] op_a_i;
  logic [23:0] op_b_i;
  logic [2:0]  gnt_o;
  logic [2:0]  done_o;
  logic [13:0] prod_o;
  logic        busy_o;
  logic        mult_start_o;
  logic [13:0] mult_op_a_o;
  logic [7:0]  mult_op_b_o;
  logic        mult_ready_i;
  logic [13:0] mult_prod_i;

  int n_checks = 0;
  int n_pass   = 0;

  mult_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .prod_o       (prod_o),
    .busy_o       (busy_o),
    .mult_start_o (mult_start_o),
    .mult_op_a_o  (mult_op_a_o),
    .mult_op_b_o  (mult_op_b_o),
    .mult_ready_i (mult_ready_i),
    .mult_prod_i  (mult_prod_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Multiplier model: result (a*b)>>8 appears mult_lat cycles after SETTLE
  int          mult_lat;
  logic        stale_mode;
  logic        force_busy;
  int          m_cnt;
  logic        m_stale;
  logic [13:0] m_pend;
  logic [13:0] m_prod;
  logic [21:0] m_full;

  assign m_full       = mult_op_a_o * mult_op_b_o;
  assign mult_ready_i = !force_busy && ((m_cnt == 0) || m_stale);
  assign mult_prod_i  = m_prod;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cnt   <= 0;
      m_stale <= 1'b0;
      m_pend  <= '0;
      m_prod  <= '0;
    end else begin
      m_stale <= 1'b0;
      if (mult_start_o) begin
        m_cnt   <= mult_lat + 1;
        m_stale <= stale_mode;
        m_pend  <= m_full[21:8];
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_prod <= m_pend;
      end
    end
  end

  int         g_cnt, g_cyc, s_cnt, s_cyc, d_cnt, d_cyc;
  logic [2:0] g_val, d_val;
  logic [13:0] d_prod;
  logic       d_busy;

  task automatic run_single(input int idx, input int a, input int b, input int bound);
    int tail;
    op_a_i[idx*14 +: 14] = 14'(a);
    op_b_i[idx*8 +: 8]   = 8'(b);
    req_i      = 3'b000;
    req_i[idx] = 1'b1;
    g_cnt = 0; g_cyc = -1; s_cnt = 0; s_cyc = -1; d_cnt = 0; d_cyc = -1;
    g_val = '0; d_val = '0; d_prod = '0; d_busy = 1'b1;
    tail = -1;
    for (int n = 0; n < bound; n++) begin
      @(posedge clk_i); #1;
      if (gnt_o != 3'b000) begin g_cnt++; g_val = gnt_o; g_cyc = n; req_i = 3'b000; end
      if (mult_start_o) begin s_cnt++; s_cyc = n; end
      if (done_o != 3'b000) begin
        d_cnt++; d_val = done_o; d_cyc = n; d_prod = prod_o; d_busy = busy_o; tail = 2;
      end else if (tail > 0) begin
        tail--;
      end
      if (tail == 0) break;
    end
    req_i = 3'b000;
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if (gnt_o !== 3'b000 || done_o !== 3'b000) $display("FAIL reset_gnt_done: gnt=%b done=%b want 000/000", gnt_o, done_o); else n_pass++;
    n_checks++; if (prod_o !== 14'd0) $display("FAIL reset_prod: got %0d want 0", prod_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0 || mult_start_o !== 1'b0) $display("FAIL reset_busy_start: busy=%b start=%b want 0/0", busy_o, mult_start_o); else n_pass++;
    n_checks++; if (mult_op_a_o !== 14'd0 || mult_op_b_o !== 8'd0) $display("FAIL reset_ops: a=%0d b=%0d want 0/0", mult_op_a_o, mult_op_b_o); else n_pass++;
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_single_job;
    mult_lat = 8;
    run_single(0, 1023, 255, 40);
    n_checks++; if (g_val !== 3'b001 || g_cnt != 1) $display("FAIL single_gnt: gnt=%b pulses=%0d want 001 x1", g_val, g_cnt); else n_pass++;
    n_checks++; if (s_cnt != 1 || s_cyc != g_cyc) $display("FAIL single_start: pulses=%0d at %0d want 1 at %0d", s_cnt, s_cyc, g_cyc); else n_pass++;
    n_checks++; if (d_val !== 3'b001 || d_cnt != 1) $display("FAIL single_done: done=%b pulses=%0d want 001 x1", d_val, d_cnt); else n_pass++;
    n_checks++; if (d_cyc - g_cyc != 11) $display("FAIL single_latency: got %0d want 11", d_cyc - g_cyc); else n_pass++;
    n_checks++; if (d_prod !== 14'd1019) $display("FAIL single_prod: got %0d want 1019", d_prod); else n_pass++;
    n_checks++; if (d_busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", d_busy); else n_pass++;
    n_checks++; if (mult_op_a_o !== 14'd1023 || mult_op_b_o !== 8'd255) $display("FAIL single_ops_held: a=%0d b=%0d want 1023/255", mult_op_a_o, mult_op_b_o); else n_pass++;
  endtask

  task automatic test_contention;
    int order[$];
    logic [2:0] rereq;
    int exp_order [6];
`ifdef MULT_ARB_RR_EN
    exp_order = '{0, 1, 2, 0, 1, 2};
`else
    exp_order = '{0, 1, 0, 1, 0, 1};
`endif
    mult_lat = 2;
    op_a_i = {14'd30, 14'd20, 14'd10};
    op_b_i = {8'd3, 8'd2, 8'd1};
    rereq  = 3'b000;
    req_i  = 3'b111;
    for (int n = 0; n < 200 && order.size() < 6; n++) begin
      @(posedge clk_i); #1;
      req_i = req_i | rereq;
      rereq = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (gnt_o[i]) begin req_i[i] = 1'b0; order.push_back(i); end
        if (done_o[i]) rereq[i] = 1'b1;
      end
    end
    req_i = 3'b000;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (k >= order.size()) $display("FAIL contention_grant%0d: no grant seen want %0d", k, exp_order[k]);
      else if (order[k] != exp_order[k]) $display("FAIL contention_grant%0d: got %0d want %0d", k, order[k], exp_order[k]);
      else n_pass++;
    end
    repeat (12) @(posedge clk_i);
    #1;
  endtask

  task automatic test_stale_ready;
    mult_lat = 3;
    run_single(1, 100, 200, 30);
    n_checks++; if (d_prod !== 14'd78) $display("FAIL stale_first_prod: got %0d want 78", d_prod); else n_pass++;
    stale_mode = 1'b1;
    run_single(2, 300, 100, 30);
    stale_mode = 1'b0;
    n_checks++; if (d_val !== 3'b100 || d_cnt != 1) $display("FAIL stale_done: done=%b pulses=%0d want 100 x1", d_val, d_cnt); else n_pass++;
    n_checks++; if (d_cyc - g_cyc != 6) $display("FAIL stale_latency: got %0d want 6", d_cyc - g_cyc); else n_pass++;
    n_checks++; if (d_prod !== 14'd117) $display("FAIL stale_prod: got %0d want 117", d_prod); else n_pass++;
  endtask

  task automatic test_reset_mid_job;
    int got_gnt;
    mult_lat = 8;
    op_a_i[13:0] = 14'd5;
    op_b_i[7:0]  = 8'd6;
    req_i   = 3'b001;
    got_gnt = 0;
    for (int n = 0; n < 20 && got_gnt == 0; n++) begin
      @(posedge clk_i); #1;
      if (gnt_o[0]) begin got_gnt = 1; req_i = 3'b000; end
    end
    n_checks++; if (got_gnt != 1) $display("FAIL midrst_first_gnt: got %0d want 1", got_gnt); else n_pass++;
    repeat (4) @(posedge clk_i);
    #1;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy_o); else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0 || done_o !== 3'b000 || gnt_o !== 3'b000) $display("FAIL midrst_ctrl: busy=%b done=%b gnt=%b want 0/000/000", busy_o, done_o, gnt_o); else n_pass++;
    n_checks++; if (prod_o !== 14'd0 || mult_op_a_o !== 14'd0 || mult_op_b_o !== 8'd0) $display("FAIL midrst_data: prod=%0d a=%0d b=%0d want 0/0/0", prod_o, mult_op_a_o, mult_op_b_o); else n_pass++;
    @(negedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    run_single(1, 20, 64, 30);
    n_checks++; if (g_val !== 3'b010) $display("FAIL midrst_regrant: got %b want 010", g_val); else n_pass++;
    n_checks++; if (d_val !== 3'b010 || d_cnt != 1) $display("FAIL midrst_done: done=%b pulses=%0d want 010 x1", d_val, d_cnt); else n_pass++;
    n_checks++; if (d_prod !== 14'd5) $display("FAIL midrst_prod: got %0d want 5", d_prod); else n_pass++;
  endtask

  task automatic test_withdraw_busy;
    int any_gnt, any_start;
    any_gnt = 0; any_start = 0;
    force_busy = 1'b1;
    op_a_i[41:28] = 14'd77;
    op_b_i[23:16] = 8'd9;
    req_i = 3'b100;
    repeat (5) begin
      @(posedge clk_i); #1;
      if (gnt_o != 3'b000) any_gnt++;
      if (mult_start_o) any_start++;
    end
    req_i = 3'b000;
    @(posedge clk_i); #1;
    force_busy = 1'b0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (gnt_o != 3'b000) any_gnt++;
      if (mult_start_o) any_start++;
    end
    n_checks++; if (any_gnt != 0) $display("FAIL withdraw_gnt: got %0d grants want 0", any_gnt); else n_pass++;
    n_checks++; if (any_start != 0) $display("FAIL withdraw_start: got %0d starts want 0", any_start); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL withdraw_busy: got %b want 0", busy_o); else n_pass++;
  endtask

  initial begin
    rst_ni     = 1'b0;
    req_i      = 3'b000;
    op_a_i     = '0;
    op_b_i     = '0;
    mult_lat   = 8;
    stale_mode = 1'b0;
    force_busy = 1'b0;
    test_reset;
    test_single_job;
    test_contention;
    test_stale_ready;
    test_reset_mid_job;
    test_withdraw_busy;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
